// File: rtl/out_write_buffer_pkg.sv
// Shared constants for the output posted-write buffer: drain FSM encoding,
// register offsets and status word layout.
package out_write_buffer_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_GAP   = 2'd2;

   localparam logic [31:0] OFF_DATA   = 32'h0000_0000;
   localparam logic [31:0] OFF_STATUS = 32'h0000_0004;

   localparam int unsigned STAT_LEVEL_LSB = 0;
   localparam int unsigned STAT_EMPTY_BIT = 2;
   localparam int unsigned STAT_FULL_BIT  = 3;
   localparam int unsigned STAT_PCNT_LSB  = 8;

   localparam logic [3:0] WE_WORD = 4'b1111;
   localparam logic [3:0] WE_NONE = 4'b0000;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; head word is visible on dout
// without a pop, so the reader can present it in the same cycle it pops.
module sync_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= din;
   end

   // Same index with differing wrap bits means the write side lapped the read side.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign level = wr_ptr - rd_ptr;
   assign dout  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/out_write_buffer.sv
// Posted-write buffer between the CPU data bus and the character output
// peripheral: word stores are queued and drained one per slot.
module out_write_buffer
   import out_write_buffer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned DRAIN_GAP = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] daddr,
   input  logic [31:0] dwdata,
   input  logic [3:0]  dwe,
   output logic [31:0] drdata,
   output logic        stall,
   output logic [31:0] p_daddr,
   output logic [31:0] p_dwdata,
   output logic [3:0]  p_dwe,
   input  logic [31:0] p_drdata
);

   localparam int unsigned LW       = $clog2(DEPTH) + 1;
   localparam int unsigned GW       = (DRAIN_GAP > 1) ? $clog2(DRAIN_GAP) : 1;
   localparam int unsigned GAP_LAST = (DRAIN_GAP > 0) ? DRAIN_GAP - 1 : 0;

   logic [1:0]    state;
   logic [1:0]    next_state;
   logic [GW-1:0] gap_cnt;
   logic [31:0]   accepted;
   logic [31:0]   last_data;
   logic [31:0]   head;
   logic [LW-1:0] level;
   logic [LW-1:0] level_after;
   logic [31:0]   level_w;
   logic [31:0]   status;
   logic          full;
   logic          empty;
   logic          data_hit;
   logic          status_hit;
   logic          word_store;
   logic          push;
   logic          pop;
   logic          unused_bits;

   assign data_hit   = (daddr == BASE_ADDR + OFF_DATA);
   assign status_hit = (daddr == BASE_ADDR + OFF_STATUS);
   assign word_store = data_hit && (dwe == WE_WORD);

   // No bypass: a store arriving while full waits even if this cycle pops.
   assign push  = word_store && !full;
   assign stall = word_store && full;
   assign pop   = (state == ST_ISSUE) && !empty;

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (dwdata),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .level (level)
   );

   assign level_after = level - LW'(1) + LW'(push);
   assign p_daddr     = BASE_ADDR;

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= next_state;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         gap_cnt   <= '0;
         accepted  <= '0;
         last_data <= '0;
      end else begin
         gap_cnt <= (state == ST_GAP) ? gap_cnt + GW'(1) : '0;
         if (push)              accepted  <= accepted + 32'd1;
         if (state == ST_ISSUE) last_data <= head;
      end
   end

   // Drain FSM next state and downstream strobe.
   always_comb begin
      next_state = state;
      p_dwe      = WE_NONE;
      p_dwdata   = last_data;
      case (state)
         ST_IDLE: begin
            if (!empty) next_state = ST_ISSUE;
         end
         ST_ISSUE: begin
            p_dwe    = WE_WORD;
            p_dwdata = head;
            if (DRAIN_GAP > 0)          next_state = ST_GAP;
            else if (level_after != '0) next_state = ST_ISSUE;
            else                        next_state = ST_IDLE;
         end
         ST_GAP: begin
            if (gap_cnt == GW'(GAP_LAST)) next_state = empty ? ST_IDLE : ST_ISSUE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   assign level_w     = 32'(level);
   assign unused_bits = ^{p_drdata[31:8], level_w[31:2]};

   always_comb begin
      status                             = '0;
      status[STAT_LEVEL_LSB +: 2]        = level_w[1:0];
      status[STAT_EMPTY_BIT]             = empty;
      status[STAT_FULL_BIT]              = full;
      status[STAT_PCNT_LSB +: 8]         = p_drdata[7:0];
   end

   always_comb begin
      drdata = '0;
      if (dwe == WE_NONE) begin
         if (data_hit)        drdata = accepted;
         else if (status_hit) drdata = status;
      end
   end

endmodule

// File: tb/tb_out_write_buffer.sv
// Directed bench for out_write_buffer: one DUT with the default drain gap and
// one with back-to-back draining, plus a peripheral stub counting its writes.
module tb_out_write_buffer;

   localparam logic [31:0] BASE = 32'h0000_0400;
   localparam logic [31:0] STAT = 32'h0000_0404;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] daddr, dwdata, drdata, p_daddr, p_dwdata, p_drdata;
   logic [3:0]  dwe, p_dwe;
   logic        stall;
   logic [31:0] daddr0, dwdata0, drdata0, p_daddr0, p_dwdata0, p_drdata0;
   logic [3:0]  dwe0, p_dwe0;
   logic        stall0;

   int          cyc = 0;
   logic [31:0] pcount = 32'h0;
   logic [31:0] log_d[$];
   int          log_c[$];
   logic [31:0] log0_d[$];
   int          log0_c[$];

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   out_write_buffer #(.BASE_ADDR(BASE), .DEPTH(8), .DRAIN_GAP(2)) u_dut (
      .clk(clk), .reset(reset), .daddr(daddr), .dwdata(dwdata), .dwe(dwe),
      .drdata(drdata), .stall(stall), .p_daddr(p_daddr), .p_dwdata(p_dwdata),
      .p_dwe(p_dwe), .p_drdata(p_drdata)
   );

   out_write_buffer #(.BASE_ADDR(BASE), .DEPTH(8), .DRAIN_GAP(0)) u_dut0 (
      .clk(clk), .reset(reset), .daddr(daddr0), .dwdata(dwdata0), .dwe(dwe0),
      .drdata(drdata0), .stall(stall0), .p_daddr(p_daddr0), .p_dwdata(p_dwdata0),
      .p_dwe(p_dwe0), .p_drdata(p_drdata0)
   );

   assign p_drdata  = pcount;
   assign p_drdata0 = 32'h0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (p_dwe == 4'hF) pcount <= pcount + 32'd1;
   end

   always @(negedge clk) begin
      if (p_dwe !== 4'h0) begin
         log_d.push_back(p_dwdata);
         log_c.push_back(cyc);
      end
      if (p_dwe0 !== 4'h0) begin
         log0_d.push_back(p_dwdata0);
         log0_c.push_back(cyc);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_bus();
      daddr = 32'h0; dwdata = 32'h0; dwe = 4'h0;
      daddr0 = 32'h0; dwdata0 = 32'h0; dwe0 = 4'h0;
   endtask

   task automatic store(input logic [31:0] d, output int stalls);
      daddr = BASE; dwdata = d; dwe = 4'hF; stalls = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!stall) break;
         stalls++;
         tick();
      end
      tick();
   endtask

   task automatic store0(input logic [31:0] d);
      daddr0 = BASE; dwdata0 = d; dwe0 = 4'hF;
      tick();
   endtask

   task automatic read(input logic [31:0] a, output logic [31:0] d);
      daddr = a; dwe = 4'h0; dwdata = 32'h0;
      @(negedge clk);
      d = drdata;
      tick();
   endtask

   task automatic read0(input logic [31:0] a, output logic [31:0] d);
      daddr0 = a; dwe0 = 4'h0; dwdata0 = 32'h0;
      @(negedge clk);
      d = drdata0;
      tick();
   endtask

   task automatic test_reset();
      logic [31:0] r;
      reset = 1'b1;
      idle_bus();
      tick(); tick();
      @(negedge clk);
      vectors++;
      if (p_dwe !== 4'h0) begin errors++; $display("FAIL reset_p_dwe: got %h want 0", p_dwe); end
      vectors++;
      if (p_dwdata !== 32'h0) begin errors++; $display("FAIL reset_p_dwdata: got %h want 0", p_dwdata); end
      vectors++;
      if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
      vectors++;
      if (p_daddr !== BASE) begin errors++; $display("FAIL p_daddr: got %h want %h", p_daddr, BASE); end
      vectors++;
      if (p_dwe0 !== 4'h0) begin errors++; $display("FAIL reset_p_dwe0: got %h want 0", p_dwe0); end
      reset = 1'b0;
      tick();
      read(BASE, r);
      vectors++;
      if (r !== 32'h0) begin errors++; $display("FAIL reset_count: got %h want 0", r); end
      read(STAT, r);
      vectors++;
      if (r !== 32'h0000_0004) begin errors++; $display("FAIL reset_status: got %h want 00000004", r); end
   endtask

   task automatic test_single();
      int c0, st;
      logic [31:0] r;
      log_d.delete(); log_c.delete();
      c0 = cyc;
      store(32'h41, st);
      idle_bus();
      repeat (8) tick();
      vectors++;
      if (st != 0) begin errors++; $display("FAIL single_stall: got %0d want 0", st); end
      vectors++;
      if (log_d.size() != 1) begin errors++; $display("FAIL single_count: got %0d writes want 1", log_d.size()); end
      if (log_d.size() >= 1) begin
         vectors++;
         if (log_d[0] !== 32'h41) begin errors++; $display("FAIL single_data: got %h want 41", log_d[0]); end
         vectors++;
         if (log_c[0] != c0 + 2) begin errors++; $display("FAIL single_latency: got %0d want %0d", log_c[0] - c0, 2); end
      end
      read(BASE, r);
      vectors++;
      if (r !== 32'd1) begin errors++; $display("FAIL single_accepted: got %0d want 1", r); end
   endtask

   task automatic test_back_to_back();
      int c0, st, stall_tot, stall_idx;
      logic [31:0] r;
      log_d.delete(); log_c.delete();
      stall_tot = 0; stall_idx = -1;
      c0 = cyc;
      // Drain frees a slot every 3 cycles, so the FIFO first fills on the 12th store.
      for (int k = 0; k < 12; k++) begin
         store(32'h61 + 32'(k), st);
         stall_tot += st;
         if (st != 0) stall_idx = k;
      end
      idle_bus();
      repeat (45) tick();
      vectors++;
      if (stall_tot != 1) begin errors++; $display("FAIL b2b_stall_cycles: got %0d want 1", stall_tot); end
      vectors++;
      if (stall_idx != 11) begin errors++; $display("FAIL b2b_stall_store: got %0d want 11", stall_idx); end
      vectors++;
      if (log_d.size() != 12) begin errors++; $display("FAIL b2b_count: got %0d want 12", log_d.size()); end
      for (int k = 0; k < 12 && k < log_d.size(); k++) begin
         vectors++;
         if (log_d[k] !== 32'h61 + 32'(k)) begin
            errors++; $display("FAIL b2b_data[%0d]: got %h want %h", k, log_d[k], 32'h61 + 32'(k));
         end
         vectors++;
         if (log_c[k] != c0 + 2 + 3 * k) begin
            errors++; $display("FAIL b2b_slot[%0d]: got %0d want %0d", k, log_c[k] - c0, 2 + 3 * k);
         end
      end
      read(BASE, r);
      vectors++;
      if (r !== 32'd13) begin errors++; $display("FAIL b2b_accepted: got %0d want 13", r); end
   endtask

   task automatic test_partial_writes();
      logic [31:0] r;
      log_d.delete(); log_c.delete();
      daddr = BASE; dwdata = 32'h99; dwe = 4'b0001;
      @(negedge clk);
      vectors++;
      if (stall !== 1'b0) begin errors++; $display("FAIL sb_stall: got %b want 0", stall); end
      tick();
      dwe = 4'b0011;
      @(negedge clk);
      vectors++;
      if (stall !== 1'b0) begin errors++; $display("FAIL sh_stall: got %b want 0", stall); end
      tick();
      daddr = STAT; dwe = 4'hF;
      tick();
      idle_bus();
      repeat (6) tick();
      vectors++;
      if (log_d.size() != 0) begin errors++; $display("FAIL partial_writes_issued: got %0d want 0", log_d.size()); end
      read(BASE, r);
      vectors++;
      if (r !== 32'd13) begin errors++; $display("FAIL partial_accepted: got %0d want 13", r); end
   endtask

   task automatic test_reset_mid_drain();
      int st;
      logic [31:0] r;
      log_d.delete(); log_c.delete();
      for (int k = 0; k < 5; k++) store(32'h71 + 32'(k), st);
      // Five cycles after the first store the second ISSUE is on the bus.
      reset = 1'b1;
      idle_bus();
      @(negedge clk);
      vectors++;
      if (p_dwe !== 4'hF || p_dwdata !== 32'h72) begin
         errors++; $display("FAIL mid_issue2: got %h/%h want f/00000072", p_dwe, p_dwdata);
      end
      tick();
      @(negedge clk);
      vectors++;
      if (p_dwe !== 4'h0) begin errors++; $display("FAIL mid_reset_p_dwe: got %h want 0", p_dwe); end
      vectors++;
      if (p_dwdata !== 32'h0) begin errors++; $display("FAIL mid_reset_p_dwdata: got %h want 0", p_dwdata); end
      reset = 1'b0;
      tick();
      repeat (10) tick();
      vectors++;
      if (log_d.size() != 2) begin errors++; $display("FAIL mid_reset_issued: got %0d want 2", log_d.size()); end
      read(BASE, r);
      vectors++;
      if (r !== 32'h0) begin errors++; $display("FAIL mid_reset_count: got %0d want 0", r); end
   endtask

   task automatic test_status();
      logic [31:0] r;
      // 1 + 12 + 2 downstream writes so far; FIFO empty.
      read(STAT, r);
      vectors++;
      if (r !== 32'h0000_0F04) begin errors++; $display("FAIL status_drained: got %h want 00000f04", r); end
      read(BASE + 32'h8, r);
      vectors++;
      if (r !== 32'h0) begin errors++; $display("FAIL status_unmapped: got %h want 0", r); end
   endtask

   task automatic test_no_gap();
      int c0, c1;
      logic [31:0] r;
      log0_d.delete(); log0_c.delete();
      c0 = cyc;
      for (int k = 0; k < 4; k++) store0(32'h81 + 32'(k));
      idle_bus();
      repeat (8) tick();
      vectors++;
      if (log0_d.size() != 4) begin errors++; $display("FAIL nogap_count: got %0d want 4", log0_d.size()); end
      for (int k = 0; k < 4 && k < log0_d.size(); k++) begin
         vectors++;
         if (log0_d[k] !== 32'h81 + 32'(k) || log0_c[k] != c0 + 2 + k) begin
            errors++;
            $display("FAIL nogap_slot[%0d]: got %h@%0d want %h@%0d", k, log0_d[k], log0_c[k] - c0,
                     32'h81 + 32'(k), 2 + k);
         end
      end
      read0(BASE, r);
      vectors++;
      if (r !== 32'd4) begin errors++; $display("FAIL nogap_accepted: got %0d want 4", r); end
      read0(STAT, r);
      vectors++;
      if (r !== 32'h0000_0004) begin errors++; $display("FAIL nogap_status: got %h want 00000004", r); end
      c1 = cyc;
      store0(32'h85);
      idle_bus();
      repeat (6) tick();
      vectors++;
      if (log0_d.size() != 5 || (log0_c.size() >= 5 && log0_c[4] != c1 + 2)) begin
         errors++; $display("FAIL nogap_idle_restart: got %0d writes want 5 at +2", log0_d.size());
      end
   endtask

   initial begin
      reset = 1'b1;
      idle_bus();
      test_reset();
      test_single();
      test_back_to_back();
      test_partial_writes();
      test_reset_mid_drain();
      test_status();
      test_no_gap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
